// File: rtl/stack_cpu_controller_if.sv
// stack_cpu_controller_if: control/status bundle between the stack CPU controller and its datapath
interface stack_cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       pc_write;
  logic       pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       push;
  logic       pop;
  logic       tos;
  logic       stack_src;
  logic       a_ld;
  logic       b_ld;
  logic [1:0] alu_op;
  logic       done;
  logic [3:0] state;
  modport master (
    input  opcode, zero,
    output pc_write, pc_src, iord, mem_read, mem_write, ir_write, push, pop, tos,
           stack_src, a_ld, b_ld, alu_op, done, state
  );
  modport slave (
    output opcode, zero,
    input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, push, pop, tos,
           stack_src, a_ld, b_ld, alu_op, done, state
  );
endinterface

// File: rtl/stack_cpu_controller.sv
// stack_cpu_controller: multicycle Moore FSM sequencing the 8-bit stack processor datapath
module stack_cpu_controller (
  input logic clk,
  input logic rst,
  stack_cpu_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_LDIR = 4'd2, S_DECODE = 4'd3,
    S_POP1 = 4'd4, S_POP2 = 4'd5, S_LDB = 4'd6, S_NOTA = 4'd7,
    S_EXEC = 4'd8, S_MRD = 4'd9, S_PUSHM = 4'd10, S_POPS = 4'd11,
    S_MWR = 4'd12, S_JMP = 4'd13, S_JZ = 4'd14
  } state_t;
  // plain vector so the unused encoding 15 is representable and recovers to IDLE
  logic [3:0] st;
  // state sequencing; opcode only matters in DECODE and POP1
  always_ff @(posedge clk)
    if (rst) st <= S_IDLE;
    else
      case (st)
        S_IDLE:   st <= S_FETCH;
        S_FETCH:  st <= S_LDIR;
        S_LDIR:   st <= S_DECODE;
        S_DECODE: st <= !bus.opcode[2] ? S_POP1 :
                        bus.opcode == 3'b100 ? S_MRD :
                        bus.opcode == 3'b101 ? S_POPS :
                        bus.opcode == 3'b110 ? S_JMP : S_JZ;
        S_POP1:   st <= bus.opcode == 3'b011 ? S_NOTA : S_POP2;
        S_POP2:   st <= S_LDB;
        S_LDB:    st <= S_EXEC;
        S_NOTA:   st <= S_EXEC;
        S_MRD:    st <= S_PUSHM;
        S_POPS:   st <= S_MWR;
        S_EXEC, S_PUSHM, S_MWR, S_JMP, S_JZ: st <= S_FETCH;
        default:  st <= S_IDLE;
      endcase
  // outputs decoded from the state register; zero gates the branch only in JZ
  assign bus.pc_write  = st == S_FETCH || st == S_JMP || (st == S_JZ && bus.zero);
  assign bus.pc_src    = st == S_JMP || st == S_JZ;
  assign bus.iord      = st == S_MRD || st == S_MWR;
  assign bus.mem_read  = st == S_FETCH || st == S_MRD;
  assign bus.mem_write = st == S_MWR;
  assign bus.ir_write  = st == S_LDIR;
  assign bus.push      = st == S_EXEC || st == S_PUSHM;
  assign bus.pop       = st == S_POP1 || st == S_POP2 || st == S_POPS;
  assign bus.tos       = st == S_DECODE;
  assign bus.stack_src = st == S_PUSHM;
  assign bus.a_ld      = st == S_POP2 || st == S_NOTA;
  assign bus.b_ld      = st == S_LDB;
  assign bus.alu_op    = st == S_EXEC ? bus.opcode[1:0] : 2'b00;
  assign bus.done      = st == S_EXEC || st == S_PUSHM || st == S_MWR || st == S_JMP || st == S_JZ;
  assign bus.state     = st;
endmodule

// File: tb/tb_stack_cpu_controller.sv
// tb_stack_cpu_controller: directed per-cycle checks of state and control outputs
module tb_stack_cpu_controller;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  stack_cpu_controller_if bus();
  stack_cpu_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [14:0] PW = 15'h4000, PS = 15'h2000, IO = 15'h1000, MR = 15'h0800,
                          MW = 15'h0400, IRW = 15'h0200, PU = 15'h0100, PO = 15'h0080,
                          TO = 15'h0040, SS = 15'h0020, AL = 15'h0010, BL = 15'h0008,
                          DN = 15'h0001;
  logic [14:0] obs;
  assign obs = {bus.pc_write, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.push, bus.pop, bus.tos, bus.stack_src, bus.a_ld, bus.b_ld, bus.alu_op, bus.done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.opcode = 3'b000;
    bus.zero = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.state !== 4'd0 || obs !== 15'h0) begin
        errors++;
        $display("FAIL reset cyc%0d state=%0d out=%h required state=0 out=0000", i, bus.state, obs);
      end
    end
    rst = 0;
    tick();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_fetch state=%0d required 1", bus.state);
    end
  endtask

  task automatic test_alu_ops();
    logic [1:0] ops[3] = '{2'b00, 2'b10, 2'b01};
    int se[7] = '{1, 2, 3, 4, 5, 6, 8};
    logic [14:0] oe[7];
    foreach (ops[k]) begin
      bus.opcode = {1'b0, ops[k]};
      oe = '{MR | PW, IRW, TO, PO, PO | AL, BL, PU | DN | {12'd0, ops[k], 1'b0}};
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (bus.state !== 4'(se[i]) || obs !== oe[i]) begin
          errors++;
          $display("FAIL alu op%0d cyc%0d state=%0d out=%h required state=%0d out=%h",
                   ops[k], i, bus.state, obs, se[i], oe[i]);
        end
        tick();
      end
      checks++;
      if (bus.state !== 4'd1) begin
        errors++;
        $display("FAIL alu op%0d length: state=%0d after 7 cycles, required 1", ops[k], bus.state);
      end
    end
  endtask

  task automatic test_not();
    int se[6] = '{1, 2, 3, 4, 7, 8};
    logic [14:0] oe[6] = '{MR | PW, IRW, TO, PO, AL, PU | DN | 15'h0006};
    bus.opcode = 3'b011;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.state !== 4'(se[i]) || obs !== oe[i]) begin
        errors++;
        $display("FAIL not cyc%0d state=%0d out=%h required state=%0d out=%h",
                 i, bus.state, obs, se[i], oe[i]);
      end
      tick();
    end
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL not length: state=%0d required 1", bus.state);
    end
  endtask

  task automatic test_push_pop();
    int se[2][5] = '{'{1, 2, 3, 9, 10}, '{1, 2, 3, 11, 12}};
    logic [14:0] oe[2][5] = '{'{MR | PW, IRW, TO, MR | IO, PU | SS | DN},
                              '{MR | PW, IRW, TO, PO, MW | IO | DN}};
    for (int k = 0; k < 2; k++) begin
      bus.opcode = k == 0 ? 3'b100 : 3'b101;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus.state !== 4'(se[k][i]) || obs !== oe[k][i]) begin
          errors++;
          $display("FAIL pushpop op%0d cyc%0d state=%0d out=%h required state=%0d out=%h",
                   bus.opcode, i, bus.state, obs, se[k][i], oe[k][i]);
        end
        tick();
      end
      checks++;
      if (bus.state !== 4'd1) begin
        errors++;
        $display("FAIL pushpop op%0d length: state=%0d required 1", bus.opcode, bus.state);
      end
    end
  endtask

  task automatic test_jumps();
    logic [2:0] op[3] = '{3'b110, 3'b111, 3'b111};
    logic zv[3] = '{1'b0, 1'b1, 1'b0};
    int last_s[3] = '{13, 14, 14};
    logic [14:0] last_o[3] = '{PW | PS | DN, PW | PS | DN, PS | DN};
    for (int k = 0; k < 3; k++) begin
      bus.opcode = op[k];
      bus.zero = ~zv[k];
      for (int i = 0; i < 4; i++) begin
        logic [14:0] oe;
        int s;
        if (i == 3) bus.zero = zv[k];
        #1;
        s = i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : last_s[k];
        oe = i == 0 ? MR | PW : i == 1 ? IRW : i == 2 ? TO : last_o[k];
        checks++;
        if (bus.state !== 4'(s) || obs !== oe) begin
          errors++;
          $display("FAIL jump op%0d zero=%0d cyc%0d state=%0d out=%h required state=%0d out=%h",
                   op[k], zv[k], i, bus.state, obs, s, oe);
        end
        tick();
      end
      checks++;
      if (bus.state !== 4'd1) begin
        errors++;
        $display("FAIL jump op%0d length: state=%0d required 1", op[k], bus.state);
      end
    end
    bus.zero = 0;
  endtask

  task automatic test_mid_reset();
    bus.opcode = 3'b000;
    repeat (4) tick();
    checks++;
    if (bus.state !== 4'd5) begin
      errors++;
      $display("FAIL midreset setup state=%0d required 5", bus.state);
    end
    rst = 1;
    tick();
    checks++;
    if (bus.state !== 4'd0 || obs !== 15'h0) begin
      errors++;
      $display("FAIL midreset abort state=%0d out=%h required state=0 out=0000", bus.state, obs);
    end
    rst = 0;
    tick();
    checks++;
    if (bus.state !== 4'd1 || obs !== (MR | PW)) begin
      errors++;
      $display("FAIL midreset restart state=%0d out=%h required state=1 out=%h", bus.state, obs, MR | PW);
    end
  endtask

  task automatic test_illegal();
    force dut.st = 4'd15;
    #1;
    checks++;
    if (bus.state !== 4'd15 || obs !== 15'h0) begin
      errors++;
      $display("FAIL illegal outputs state=%0d out=%h required state=15 out=0000", bus.state, obs);
    end
    release dut.st;
    tick();
    checks++;
    if (bus.state !== 4'd0 || obs !== 15'h0) begin
      errors++;
      $display("FAIL illegal recover state=%0d out=%h required state=0 out=0000", bus.state, obs);
    end
    tick();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL illegal refetch state=%0d required 1", bus.state);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_not();
    test_push_pop();
    test_jumps();
    test_mid_reset();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_cpu_controller.md
# stack_cpu_controller

Multicycle Moore controller that sequences the 8-bit stack processor datapath. The datapath has a 32x8 unified instruction/data memory with a registered read, a 32-deep stack with push/pop/tos controls, PC, IR, A/B operand registers and an ALU. Each instruction is fetched, decoded and executed in 4–7 cycles, and the controller drives every load/enable/select in the datapath. Instruction format: IR[7:5] opcode, IR[4:0] memory/jump address.

## Interface
- No parameters. State width is fixed at 4 bits.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  3  IR[7:5]: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ
- zero  in  1  high when stack d_out == 0
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = PC+1, 1 = IR[4:0]
- iord  out  1  memory address select: 0 = PC, 1 = IR[4:0]
- mem_read  out  1  memory read enable; data valid the cycle after the edge
- mem_write  out  1  memory write enable; write_data = stack d_out
- ir_write  out  1  IR load from memory read_data
- push / pop / tos  out  1 each  stack controls
- stack_src  out  1  stack d_in select: 0 = ALU result, 1 = memory read_data
- a_ld, b_ld  out  1 each  A/B load from stack d_out
- alu_op  out  2  00 add, 01 sub (A−B), 10 and, 11 not A
- done  out  1  one-cycle pulse in the last state of each instruction
- state  out  4  current state encoding, for debug

## Operation
- States and encodings: IDLE 0, FETCH 1, LDIR 2, DECODE 3, POP1 4, POP2 5, LDB 6, NOTA 7, EXEC 8, MRD 9, PUSHM 10, POPS 11, MWR 12, JMP 13, JZ 14.
- Outputs are decoded only from the state register. Any output not listed for a state is 0.
- IDLE: no outputs → FETCH.
- FETCH: mem_read, iord=0, pc_write, pc_src=0 → LDIR.
- LDIR: ir_write → DECODE.
- DECODE: tos → next state by opcode:
  - ADD/SUB/AND/NOT → POP1
  - PUSH → MRD
  - POP → POPS
  - JMP → JMP
  - JZ → JZ
- POP1: pop → POP2 for ADD/SUB/AND; → NOTA for NOT.
- POP2: pop, a_ld → LDB.
- LDB: b_ld → EXEC.
- NOTA: a_ld → EXEC.
- EXEC: push, stack_src=0, alu_op = opcode[1:0], done → FETCH.
- MRD: mem_read, iord=1 → PUSHM.
- PUSHM: push, stack_src=1, done → FETCH.
- POPS: pop → MWR.
- MWR: mem_write, iord=1, done → FETCH.
- JMP: pc_write, pc_src=1, done → FETCH.
- JZ: pc_src=1, pc_write=zero, done → FETCH.
- Unused encoding 15 → IDLE on the next edge, with all outputs 0.
- opcode is sampled only in DECODE and POP1. zero is sampled only in JZ.

## Timing
- Reset: rst high at an edge → state=IDLE and all outputs 0 in the following cycle. First FETCH comes one cycle after rst falls.
- Reset mid-instruction aborts the instruction. Memory, stack and PC effects already committed are not undone, and no done pulse is issued.
- Cycles per instruction, counted from FETCH through the done cycle:
  - ADD/SUB/AND: 7
  - NOT: 6
  - PUSH/POP: 5
  - JMP/JZ: 4
- Memory read latency is 1 cycle: FETCH→LDIR and MRD→PUSHM.
- Stack d_out is valid one cycle after pop or tos: POP1→POP2 a_ld, POP2→LDB b_ld, POPS→MWR, DECODE→JZ zero.
- SUB computes A−B, where A is the first-popped (top) operand. The result is 8-bit and wraps modulo 256; no carry or overflow is reported.
- done is high exactly one cycle per completed instruction. The next FETCH follows immediately.

## Test plan
- Reset: hold rst 3 cycles, then release → state 0 and all outputs 0 while rst is high and for one cycle after; FETCH (state=1) the cycle after that.
- ADD sequence: opcode=000 → states 1,2,3,4,5,6,8. a_ld only in 5, b_ld only in 6, push+done with alu_op=00, stack_src=0 in 8. 7 cycles total.
- NOT and SUB: opcode=011 → 1,2,3,4,7,8 with alu_op=11. opcode=001 → EXEC alu_op=01.
- PUSH/POP: opcode=100 → 1,2,3,9,10 with iord=1+mem_read in 9, push+stack_src=1 in 10. opcode=101 → 1,2,3,11,12 with pop in 11, mem_write+iord=1 in 12.
- JZ both ways: opcode=111, zero=1 → pc_write=1, pc_src=1 in state 14. zero=0 → pc_write=0. JMP (110) → pc_write=1 in state 13. Each is 4 cycles.
- Mid-op reset and illegal state: assert rst in state 5 → IDLE next cycle, no done, no push. Force state=15 → IDLE next cycle with all outputs 0.
